// File: rtl/mem_tag_responder_pkg.sv
// Purpose: shared types for the tagged block-memory protocol (tags, blocks, address and response packets).
// Latency: n/a, this file holds only types, constants and a helper function.
// Backpressure: n/a.
// Contents: MEM_TAG, MEM_BLOCK, I_ADDR_PACKET {valid, addr}, MEM_RESP_PACKET {tag, data}, lowest_free_tag().
// `NUM_MEM_TAGS sets the number of usable tags (1..NUM_TAGS). Tag 0 means "no tag / no data".
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

package mem_tag_responder_pkg;

  localparam int NUM_TAGS   = `NUM_MEM_TAGS;
  localparam int TAG_BITS   = $clog2(NUM_TAGS + 1);
  localparam int ADDR_BITS  = 32;
  localparam int BLOCK_BITS = 64;

  typedef logic [TAG_BITS-1:0]   MEM_TAG;
  typedef logic [BLOCK_BITS-1:0] MEM_BLOCK;

  typedef struct packed {
    logic                 valid;
    logic [ADDR_BITS-1:0] addr;
  } I_ADDR_PACKET;

  typedef struct packed {
    MEM_TAG   tag;
    MEM_BLOCK data;
  } MEM_RESP_PACKET;

  // Bit i-1 of free_map represents tag i. Returns the lowest free tag, or 0 if none is free.
  function automatic MEM_TAG lowest_free_tag(input logic [NUM_TAGS-1:0] free_map);
    MEM_TAG tag;
    tag = '0;
    for (int i = NUM_TAGS; i >= 1; i--) begin
      if (free_map[i-1]) tag = MEM_TAG'(i);
    end
    return tag;
  endfunction

endpackage

// File: rtl/mem_tag_responder_tag_free_list.sv
// Purpose: free-tag bitmap with a combinational lowest-free offer. It can allocate and free in the same cycle.
// Latency: the offer is combinational. Alloc and free take effect at the next clock edge.
// Backpressure: o_any_free low means there is nothing to grant, and i_alloc is then ignored.
// Ports: clock, reset (async active-low); i_alloc takes the offered tag; i_free_vld/i_free_tag return a tag;
//        o_any_free reports that at least one tag is free; o_tag is the lowest free tag (0 if none).
module mem_tag_responder_tag_free_list
  import mem_tag_responder_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                i_alloc,
  input  logic                i_free_vld,
  input  logic [TAG_BITS-1:0] i_free_tag,
  output logic                o_any_free,
  output logic [TAG_BITS-1:0] o_tag
);

  logic [NUM_TAGS-1:0] r_free;
  logic [NUM_TAGS-1:0] w_alloc_mask;
  logic [NUM_TAGS-1:0] w_free_mask;

  assign o_any_free = |r_free;
  assign o_tag      = lowest_free_tag(r_free);

  // The tag being freed is busy, and the offer is taken from the current map.
  // So the alloc and free masks never overlap.
  always_comb begin
    w_alloc_mask = '0;
    w_free_mask  = '0;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      if (i_alloc && o_any_free && (o_tag == MEM_TAG'(i))) w_alloc_mask[i-1] = 1'b1;
      if (i_free_vld && (i_free_tag == MEM_TAG'(i)))       w_free_mask[i-1]  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_free <= '1;
    end else begin
      r_free <= (r_free & ~w_alloc_mask) | w_free_mask;
    end
  end

endmodule

// File: rtl/mem_tag_responder.sv
// Purpose: memory-side responder. It grants a tag for each block read and returns the block LATENCY cycles later.
//          It also absorbs writeback pulses into a local block store.
// Latency: a read accepted in cycle c responds in cycle c+LATENCY. Writes land at the clock edge.
// Backpressure: a read is refused (req_accepted=0) only when all tags are busy. Writes are never refused.
// Ports: clock, reset (async active-low); req_addr/req_accepted/req_tag form the read request channel;
//        wr_valid/wr_addr/wr_data carry the writeback; resp_data/resp_tag carry the response (tag 0 = none).
// Optional: define MEM_RESPONDER_STATS_EN to add the saturating stat_reads/stat_writes/stat_stalls outputs.
module mem_tag_responder
  import mem_tag_responder_pkg::*;
#(
  parameter int LATENCY        = 4,
  parameter int BLOCK_IDX_BITS = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [$bits(I_ADDR_PACKET)-1:0]  req_addr,
  output logic                             req_accepted,
  output logic [$bits(MEM_TAG)-1:0]        req_tag,
  input  logic                             wr_valid,
  input  logic [$bits(I_ADDR_PACKET)-1:0]  wr_addr,
  input  logic [$bits(MEM_BLOCK)-1:0]      wr_data,
  output logic [$bits(MEM_BLOCK)-1:0]      resp_data,
  output logic [$bits(MEM_TAG)-1:0]        resp_tag
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]                      stat_reads,
  output logic [31:0]                      stat_writes,
  output logic [31:0]                      stat_stalls
`endif
);

  localparam int NUM_BLOCKS = 1 << BLOCK_IDX_BITS;

  I_ADDR_PACKET              w_req;
  I_ADDR_PACKET              w_wr;
  logic [BLOCK_IDX_BITS-1:0] w_req_idx;
  logic [BLOCK_IDX_BITS-1:0] w_wr_idx;
  logic [BLOCK_IDX_BITS-1:0] w_resp_idx;
  logic                      w_any_free;
  MEM_TAG                    w_offer_tag;
  logic                      w_accept;
  MEM_RESP_PACKET            w_resp;

  assign w_req = req_addr;
  assign w_wr  = wr_addr;

  // The byte offset and the upper bits are dropped, so addresses alias modulo the store size.
  assign w_req_idx = w_req.addr[BLOCK_IDX_BITS+2:3];
  assign w_wr_idx  = w_wr.addr[BLOCK_IDX_BITS+2:3];

  logic w_unused;
  assign w_unused = ^{w_req.addr[ADDR_BITS-1:BLOCK_IDX_BITS+3], w_req.addr[2:0],
                      w_wr.valid, w_wr.addr[ADDR_BITS-1:BLOCK_IDX_BITS+3], w_wr.addr[2:0]};

  assign w_accept     = w_req.valid && w_any_free;
  assign req_accepted = w_accept;
  assign req_tag      = w_accept ? w_offer_tag : '0;

  mem_tag_responder_tag_free_list u_free_list (
    .clock      (clock),
    .reset      (reset),
    .i_alloc    (w_accept),
    .i_free_vld (w_resp.tag != '0),
    .i_free_tag (w_resp.tag),
    .o_any_free (w_any_free),
    .o_tag      (w_offer_tag)
  );

  // Tag/index shift pipeline. Stage LATENCY-1 is the response cycle, and a zero tag marks an empty slot.
  MEM_TAG                    r_pipe_tag [LATENCY];
  logic [BLOCK_IDX_BITS-1:0] r_pipe_idx [LATENCY];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe_tag[i] <= '0;
        r_pipe_idx[i] <= '0;
      end
    end else begin
      r_pipe_tag[0] <= req_tag;
      r_pipe_idx[0] <= w_req_idx;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_tag[i] <= r_pipe_tag[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

  // The block store has no reset, so its contents survive a reset.
  MEM_BLOCK r_store [NUM_BLOCKS];

  always_ff @(posedge clock) begin
    if (wr_valid) r_store[w_wr_idx] <= wr_data;
  end

  assign w_resp_idx = r_pipe_idx[LATENCY-1];

  // The store is read late, in the response cycle, so every earlier write is visible.
  // A write to the same block in the response cycle itself is forwarded.
  always_comb begin
    w_resp     = '0;
    w_resp.tag = r_pipe_tag[LATENCY-1];
    if (w_resp.tag != '0) begin
      if (wr_valid && (w_wr_idx == w_resp_idx)) w_resp.data = wr_data;
      else                                      w_resp.data = r_store[w_resp_idx];
    end
  end

  assign resp_tag  = w_resp.tag;
  assign resp_data = w_resp.data;

`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] r_stat_reads;
  logic [31:0] r_stat_writes;
  logic [31:0] r_stat_stalls;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stat_reads  <= '0;
      r_stat_writes <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (w_accept && (r_stat_reads != '1))                r_stat_reads  <= r_stat_reads + 32'd1;
      if (wr_valid && (r_stat_writes != '1))               r_stat_writes <= r_stat_writes + 32'd1;
      if (w_req.valid && !w_accept && (r_stat_stalls != '1)) r_stat_stalls <= r_stat_stalls + 32'd1;
    end
  end

  assign stat_reads  = r_stat_reads;
  assign stat_writes = r_stat_writes;
  assign stat_stalls = r_stat_stalls;
`endif

endmodule
